// File: rtl/tpm_pkg.sv
// Shared constants and helpers for the triple-ported memory response path.
package tpm_pkg;
  localparam int NUM_PORTS  = 3;
  localparam int NUM_BANKS  = 4;
  localparam int TAG_W      = 2;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 12;
  localparam int BANK_SEL_W = 2;
  localparam int RESP_W     = TAG_W + DATA_W;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } resp_t;

  // Lowest-index bank with valid set wins; returns 0 when none is set.
  function automatic logic [BANK_SEL_W-1:0] lowest_bank(input logic [NUM_BANKS-1:0] v);
    lowest_bank = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (v[b]) lowest_bank = BANK_SEL_W'(b);
    end
  endfunction
endpackage

// File: rtl/resp_fifo.sv
// Per-port response FIFO with registered almost-full and sticky overflow flag.
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_almost_full,
  output logic             o_overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_almost_full;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic [CNT_W-1:0] w_count_next;

  assign w_full    = (r_count == FULL_LVL);
  assign w_pop     = (r_count != '0) && i_ready;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign w_push_ok = i_push && (!w_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop)      w_count_next = r_count + CNT_W'(1);
    else if (!w_push_ok && w_pop) w_count_next = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count       <= w_count_next;
      r_almost_full <= (w_count_next >= AF_LVL);
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_valid       = (r_count != '0);
  assign o_rdata       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_almost_full = r_almost_full;
  assign o_overflow    = r_overflow;
endmodule

// File: rtl/bank_response_collector.sv
// Merges 4 bank response lanes per port into a per-port FIFO with valid/ready output.
// Optional collision detection is compiled in with TPM_RESP_COLLISION_CHECK_EN.
module bank_response_collector
  import tpm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  port1_bank_valid,
  input  logic [7:0]  port1_bank_tag,
  input  logic [63:0] port1_bank_data,
  output logic        port1_resp_valid,
  input  logic        port1_resp_ready,
  output logic [1:0]  port1_resp_tag,
  output logic [15:0] port1_resp_data,
  output logic        port1_almost_full,
  input  logic [3:0]  port2_bank_valid,
  input  logic [7:0]  port2_bank_tag,
  input  logic [63:0] port2_bank_data,
  output logic        port2_resp_valid,
  input  logic        port2_resp_ready,
  output logic [1:0]  port2_resp_tag,
  output logic [15:0] port2_resp_data,
  output logic        port2_almost_full,
  input  logic [3:0]  port3_bank_valid,
  input  logic [7:0]  port3_bank_tag,
  input  logic [63:0] port3_bank_data,
  output logic        port3_resp_valid,
  input  logic        port3_resp_ready,
  output logic [1:0]  port3_resp_tag,
  output logic [15:0] port3_resp_data,
  output logic        port3_almost_full,
  output logic [2:0]  err_overflow,
  output logic [2:0]  err_collision
);
  // Handshake: a head transfers on a rising edge where resp_valid && resp_ready;
  // valid never depends on ready, and ready while valid is low is ignored.
  logic [NUM_BANKS-1:0]        w_bv [NUM_PORTS];
  logic [NUM_BANKS*TAG_W-1:0]  w_bt [NUM_PORTS];
  logic [NUM_BANKS*DATA_W-1:0] w_bd [NUM_PORTS];
  logic [NUM_PORTS-1:0]        w_ready;
  logic [NUM_PORTS-1:0]        w_rv;
  logic [NUM_PORTS-1:0]        w_af;
  logic [NUM_PORTS-1:0]        w_ovf;
  logic [RESP_W-1:0]           w_rdata [NUM_PORTS];

  assign w_bv[0] = port1_bank_valid;
  assign w_bv[1] = port2_bank_valid;
  assign w_bv[2] = port3_bank_valid;
  assign w_bt[0] = port1_bank_tag;
  assign w_bt[1] = port2_bank_tag;
  assign w_bt[2] = port3_bank_tag;
  assign w_bd[0] = port1_bank_data;
  assign w_bd[1] = port2_bank_data;
  assign w_bd[2] = port3_bank_data;
  assign w_ready = {port3_resp_ready, port2_resp_ready, port1_resp_ready};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [BANK_SEL_W-1:0] w_sel;
    resp_t                 w_entry;

    assign w_sel        = lowest_bank(w_bv[p]);
    assign w_entry.tag  = w_bt[p][{w_sel, 1'b0} +: TAG_W];
    assign w_entry.data = w_bd[p][{w_sel, 4'b0000} +: DATA_W];

    resp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RESP_W)
    ) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .i_push        (|w_bv[p]),
      .i_wdata       (w_entry),
      .i_ready       (w_ready[p]),
      .o_valid       (w_rv[p]),
      .o_rdata       (w_rdata[p]),
      .o_almost_full (w_af[p]),
      .o_overflow    (w_ovf[p])
    );
  end

  assign port1_resp_valid  = w_rv[0];
  assign port2_resp_valid  = w_rv[1];
  assign port3_resp_valid  = w_rv[2];
  assign port1_resp_tag    = w_rdata[0][RESP_W-1:DATA_W];
  assign port2_resp_tag    = w_rdata[1][RESP_W-1:DATA_W];
  assign port3_resp_tag    = w_rdata[2][RESP_W-1:DATA_W];
  assign port1_resp_data   = w_rdata[0][DATA_W-1:0];
  assign port2_resp_data   = w_rdata[1][DATA_W-1:0];
  assign port3_resp_data   = w_rdata[2][DATA_W-1:0];
  assign port1_almost_full = w_af[0];
  assign port2_almost_full = w_af[1];
  assign port3_almost_full = w_af[2];
  assign err_overflow      = w_ovf;

`ifdef TPM_RESP_COLLISION_CHECK_EN
  logic [NUM_PORTS-1:0] w_coll;
  logic [NUM_PORTS-1:0] r_err_collision;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  always_comb begin
    w_coll = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_coll[p] = |(w_bv[p] & (w_bv[p] - 4'd1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err_collision <= '0;
    else     r_err_collision <= r_err_collision | w_coll;
  end

  assign err_collision = r_err_collision;
`else
  assign err_collision = 3'b000;
`endif
endmodule
